// File: rtl/alu_issue_stage_pkg.sv
// Shared op encodings, FSM state type and op legality check for the ALU issue stage.
package alu_issue_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer holding {a, b, op, cin}; head visible combinationally, 1-cycle write-to-read.
// Push is ignored when full and pop when empty; no bypass when full.
module alu_req_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int DW        = 2*WIDTH + 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issues buffered requests to an external ALU, gives it one settle cycle, registers the response.
// Response valid 2 cycles after acceptance; response held stable until rsp_ready, FIFO absorbs the rest.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic             req_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    localparam int DW = 2*WIDTH + 4;

    state_t           state;
    logic             full;
    logic             empty;
    logic             pop;
    logic             op_illegal;
    logic [DW-1:0]    head_data;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [2:0]       head_op;
    logic             head_cin;

    assign req_ready = !full;
    assign {head_a, head_b, head_op, head_cin} = head_data;
    // HOLD implies rsp_valid, so rsp_ready alone completes the handshake there.
    assign pop = !empty && ((state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready));

    alu_req_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data ({req_a, req_b, req_op, req_cin}),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_AND;
            alu_cin     <= 1'b0;
            op_illegal  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_cout    <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (pop) begin
                alu_a      <= head_a;
                alu_b      <= head_b;
                alu_op     <= head_op;
                alu_cin    <= head_cin;
                op_illegal <= !is_legal_op(head_op);
            end
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    // Illegal ops still pass through here to keep response order.
                    if (op_illegal) begin
                        rsp_result <= '0;
                        rsp_cout   <= 1'b0;
                        rsp_zero   <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_cout   <= alu_cout;
                        rsp_zero   <= (alu_result == '0);
                    end
                    rsp_illegal <= op_illegal;
                    rsp_valid   <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? ST_DRIVE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
